// File: rtl/acc_stream_if.sv
// Stream/adder bundle for acc_stream: term input stream, result output stream and the
// operand/sum wires to the shared external combinational adder.
interface acc_stream_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_ans;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    // Accumulator side
    modport slave (
        input  in_valid, in_data, out_ready, add_ans,
        output in_ready, out_valid, out_data, out_ovf, add_a, add_b
    );

    // Producer/consumer/adder side
    modport master (
        output in_valid, in_data, out_ready, add_ans,
        input  in_ready, out_valid, out_data, out_ovf, add_a, add_b
    );
endinterface

// File: rtl/acc_stream.sv
// Streaming window accumulator wrapped around a shared combinational adder.
// Sums windows of cfg_len signed terms and emits one result per window with sticky overflow.
module acc_stream #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [LEN_W-1:0] cfg_len,
    acc_stream_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len_q;
    logic             r_ovf_acc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ovf;

    logic             w_first;
    logic             w_ready_core;
    logic             w_accept;
    logic             w_ovf;
    logic             w_last;
    logic [LEN_W-1:0] w_len_eff;

    // Any beat taken outside ACC opens a new window, so the adder starts from zero.
    assign w_first      = (r_state != S_ACC);
    assign w_ready_core = !flush && ((r_state != S_OUT) || bus.out_ready);
    assign w_accept     = bus.in_valid && w_ready_core;
    assign w_len_eff    = (cfg_len == '0) ? LEN_ONE : cfg_len;
    assign w_last       = (r_cnt == (r_len_q - LEN_ONE));

    assign bus.add_a = w_first ? '0 : r_acc;
    assign bus.add_b = bus.in_data;
    assign w_ovf     = (bus.add_a[WIDTH-1] == bus.add_b[WIDTH-1]) &&
                       (bus.add_ans[WIDTH-1] != bus.add_a[WIDTH-1]);

    // rst_n gates only the output, so accept logic stays free of the reset net.
    assign bus.in_ready  = rst_n && w_ready_core;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len_q     <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_first) begin
                // In OUT this also consumes the pending result (out_ready is implied).
                r_len_q <= w_len_eff;
                if (w_len_eff == LEN_ONE) begin
                    r_out_data  <= bus.add_ans;
                    r_out_ovf   <= w_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end else begin
                    r_acc       <= bus.add_ans;
                    r_ovf_acc   <= w_ovf;
                    r_cnt       <= LEN_ONE;
                    r_out_valid <= 1'b0;
                    r_state     <= S_ACC;
                end
            end else if (w_last) begin
                r_out_data  <= bus.add_ans;
                r_out_ovf   <= r_ovf_acc | w_ovf;
                r_out_valid <= 1'b1;
                r_cnt       <= '0;
                r_state     <= S_OUT;
            end else begin
                r_acc     <= bus.add_ans;
                r_ovf_acc <= r_ovf_acc | w_ovf;
                r_cnt     <= r_cnt + LEN_ONE;
            end
        end else if ((r_state == S_OUT) && bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acc_stream.sv
// Self-checking bench for acc_stream: the bench models the external adder, queues expected
// window results as stimulus is driven and compares them when the DUT hands them off.
module tb_acc_stream;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] cfg_len;

    acc_stream_if #(.WIDTH(32)) bus ();

    acc_stream #(.WIDTH(32), .LEN_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .cfg_len (cfg_len),
        .bus     (bus)
    );

    // Shared adder lives outside the DUT
    assign bus.add_ans = bus.add_a + bus.add_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];   // {ovf, data}
    logic [31:0] last_add_a;
    int          last_wait;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a result is consumed when out_valid && out_ready at a rising edge
    always @(negedge clk) begin
        if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got data=%h ovf=%0b, required no result",
                         bus.out_data, bus.out_ovf);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({bus.out_ovf, bus.out_data} !== e) begin
                    n_fail++;
                    $display("FAIL sb_result: got data=%h ovf=%0b, required data=%h ovf=%0b",
                             bus.out_data, bus.out_ovf, e[31:0], e[32]);
                end else begin
                    $display("result data=%h ovf=%0b", bus.out_data, bus.out_ovf);
                end
            end
        end
    end

    // Presents one term and returns at posedge+1 of the accepting edge; in_valid stays high.
    task automatic drive_beat(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                last_add_a = bus.add_a;
                last_wait  = k;
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready never rose for term %h, required accept", d);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
        n_checks++;
        if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_out_ovf: got %b required 0", bus.out_ovf); end
        n_checks++;
        if (bus.add_a !== 32'h0) begin n_fail++; $display("FAIL rst_add_a: got %h required 0", bus.add_a); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", bus.in_ready); end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [31:0] exp_a[4];
        exp_a = '{32'd0, 32'd1, 32'd3, 32'd6};
        cfg_len = 8'd4;
        bus.out_ready = 1'b1;
        exp_q.push_back({1'b0, 32'd10});
        for (int i = 0; i < 4; i++) begin
            drive_beat(32'(i + 1));
            n_checks++;
            if (last_wait != 0) begin n_fail++; $display("FAIL basic_in_ready: beat %0d waited %0d cycles, required 0", i, last_wait); end
            n_checks++;
            if (last_add_a !== exp_a[i]) begin n_fail++; $display("FAIL basic_add_a: beat %0d got %h required %h", i, last_add_a, exp_a[i]); end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: out_valid %b required 1", bus.out_valid); end
        wait_drain();
        $display("test_basic done");
    endtask

    task automatic test_overflow();
        cfg_len = 8'd3;
        bus.out_ready = 1'b1;
        exp_q.push_back({1'b1, 32'h7FFF_FFFF});
        drive_beat(32'h7FFF_FFFF);
        drive_beat(32'h0000_0001);
        drive_beat(32'hFFFF_FFFF);
        exp_q.push_back({1'b0, 32'd15});
        for (int i = 0; i < 3; i++) drive_beat(32'd5);
        bus.in_valid = 1'b0;
        wait_drain();
        $display("test_overflow done");
    endtask

    task automatic test_backpressure();
        cfg_len = 8'd2;
        bus.out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd7});
        drive_beat(32'd3);
        drive_beat(32'd4);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %b required 1", c, bus.out_valid); end
            n_checks++;
            if (bus.out_data !== 32'd7) begin n_fail++; $display("FAIL bp_data: cycle %0d got %h required 7", c, bus.out_data); end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b required 0", c, bus.in_ready); end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        exp_q.push_back({1'b0, 32'd30});
        drive_beat(32'd10);
        bus.in_valid = 1'b0;
        n_checks++;
        if (last_wait != 0) begin n_fail++; $display("FAIL bp_same_cycle: waited %0d cycles, required 0", last_wait); end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consumed: out_valid %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.add_a !== 32'd10) begin n_fail++; $display("FAIL bp_new_window: add_a %h required 0000000a", bus.add_a); end
        @(posedge clk);
        #1;
        drive_beat(32'd20);
        bus.in_valid = 1'b0;
        wait_drain();
        $display("test_backpressure done");
    endtask

    task automatic test_len0();
        cfg_len = 8'd0;
        bus.out_ready = 1'b1;
        exp_q.push_back({1'b0, 32'hFFFF_FFFD});
        exp_q.push_back({1'b0, 32'd8});
        drive_beat(32'hFFFF_FFFD);
        drive_beat(32'd8);
        bus.in_valid = 1'b0;
        n_checks++;
        if (last_wait != 0) begin n_fail++; $display("FAIL len0_throughput: waited %0d cycles, required 0", last_wait); end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd8) begin
            n_fail++;
            $display("FAIL len0_second: valid=%b data=%h required valid=1 data=00000008", bus.out_valid, bus.out_data);
        end
        wait_drain();
        $display("test_len0 done");
    endtask

    task automatic test_flush();
        cfg_len = 8'd4;
        bus.out_ready = 1'b1;
        drive_beat(32'd9);
        drive_beat(32'd9);
        bus.in_data = 32'd100;
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b required 0", bus.in_ready); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.add_a !== 32'd0) begin n_fail++; $display("FAIL flush_idle: add_a %h required 0", bus.add_a); end
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 32'd4});
        for (int i = 0; i < 4; i++) drive_beat(32'd1);
        bus.in_valid = 1'b0;
        wait_drain();
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        cfg_len = 8'd3;
        bus.out_ready = 1'b1;
        drive_beat(32'd1);
        drive_beat(32'd2);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.add_a !== 32'd0) begin n_fail++; $display("FAIL arst_mid_window: add_a %h required 0", bus.add_a); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready: got %b required 0", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cfg_len = 8'd1;
        bus.out_ready = 1'b0;
        drive_beat(32'd5);
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pending: out_valid %b required 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_drop: out_valid %b required 0", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL arst_out_data: got %h required 0", bus.out_data); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        cfg_len = 8'd2;
        exp_q.push_back({1'b0, 32'd13});
        drive_beat(32'd6);
        n_checks++;
        if (last_add_a !== 32'd0) begin n_fail++; $display("FAIL arst_fresh: add_a %h required 0", last_add_a); end
        drive_beat(32'd7);
        bus.in_valid = 1'b0;
        wait_drain();
        $display("test_async_reset done");
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        cfg_len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b1;
        last_add_a    = 32'd0;
        last_wait     = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_len0();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_stream.md
Name: acc_stream

Overview:
- Streaming accumulator that sits around the shared combinational `adder`.
- Each cycle it drives the adder's operand inputs and registers the adder's sum back into its accumulator.
- It consumes a valid/ready stream of WIDTH-bit signed terms and sums windows of `cfg_len` terms.
- It emits one result per window on a valid/ready output with a sticky signed-overflow flag.
- Used downstream of the neuron product stage and upstream of activation/writeback.

Parameters:
- WIDTH, 32, data width of terms, accumulator and result (two's complement).
- LEN_W, 8, width of the window length and term counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards partial window and pending result.
- cfg_len  input  LEN_W  terms per window, sampled on the first accepted beat of a window; 0 is treated as 1.
- in_valid  input  1  input term valid.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  WIDTH  signed input term.
- add_a  output  WIDTH  adder operand a (accumulator, or 0 on a window's first beat).
- add_b  output  WIDTH  adder operand b (= in_data).
- add_ans  input  WIDTH  adder sum (combinational, same cycle).
- out_valid  output  1  window result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  window sum.
- out_ovf  output  1  signed overflow occurred on any add in this window.

Behaviour:
- Reset (rst_n low, async): state=IDLE, acc=0, cnt=0, len_q=0, ovf_acc=0, out_valid=0, out_data=0, out_ovf=0.
- in_ready is 0 while rst_n is low.
- States:
  - IDLE: no window open.
  - ACC: window open, cnt terms accepted.
  - OUT: result held, out_valid=1.
- in_ready = (state != OUT) || out_ready. No combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready.
- Adder drive (combinational, every cycle):
  - add_b = in_data.
  - add_a = 0 when the beat is the first of a window (state IDLE, or state OUT), else acc.
- Overflow per add: add_a[MSB]==add_b[MSB] && add_ans[MSB]!=add_a[MSB]. Sum wraps modulo 2^WIDTH; no saturation.
- On accepted first beat:
  - len_q <= (cfg_len==0 ? 1 : cfg_len).
  - If len_q would be 1: out_data <= add_ans, out_ovf <= ovf, state <= OUT.
  - Else: acc <= add_ans, ovf_acc <= ovf, cnt <= 1, state <= ACC.
- On accepted beat in ACC:
  - If cnt == len_q-1 (last beat): out_data <= add_ans, out_ovf <= ovf_acc | ovf, state <= OUT, cnt <= 0.
  - Else: acc <= add_ans, ovf_acc |= ovf, cnt++.
- OUT:
  - out_valid=1; out_data and out_ovf are stable until the handshake.
  - On out_ready && !accept: state <= IDLE.
  - On out_ready && accept: the result is consumed and the beat starts a new window in the same cycle (full throughput).
- Latency: out_valid asserts the cycle after the last term is accepted.
- Throughput: one term per cycle when out_ready is held high.
- ACC with in_valid low: hold all state. Gaps between terms are allowed.
- cfg_len changes mid-window are ignored until the next first beat.
- flush (priority over all, including a simultaneous handshake): state <= IDLE, cnt <= 0, acc <= 0, ovf_acc <= 0, out_valid <= 0. out_data and out_ovf hold their values and are don't-care. While flush is high, in_ready=0 and no beat is accepted.
- Reset asserted mid-window or with a pending result: all state cleared immediately; the result is lost.
- cnt never exceeds len_q-1. Max window is 2^LEN_W-1 terms.

Test Plan:
- cfg_len=4, terms 1,2,3,4 back-to-back, out_ready=1 → out_valid one cycle after the 4th beat, out_data=10, out_ovf=0. in_ready stays high throughout.
- cfg_len=3, WIDTH=32, terms 0x7FFFFFFF,1,-1 → out_data=0x7FFFFFFF, out_ovf=1 (sticky despite the wrap back). Next window 5,5,5 → 15, ovf=0.
- cfg_len=2, out_ready=0 for 5 cycles after the result → out_valid and out_data=7 held stable, in_ready=0. Release out_ready with in_valid high → result consumed and the new window's first beat accepted in the same cycle.
- cfg_len=0, terms -3,8 → two results, -3 then 8, on consecutive cycles (length treated as 1).
- cfg_len=4, 2 terms accepted, then flush → state IDLE, no out_valid. Next 4 terms 1,1,1,1 → out_data=4.
- Assert rst_n low asynchronously mid-window and again during OUT → out_valid drops immediately, with no clock edge needed. After release, the first beat starts a fresh window.
